// File: rtl/wshb_arbiter.sv
// Two-master, one-slave classic Wishbone arbiter with round-robin grant,
// a mandatory idle cycle between owners and optional hold-limit preemption.
module wshb_arbiter #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32,
  parameter int MAX_HOLD   = 0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,

  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_W-1:0]       m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,

  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_W-1:0]       m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,

  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,

  output logic [1:0]              grant
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t              state_q, state_d;
  logic                last_owner_q, last_owner_d;  // 1 = M1 owned last
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                term;
  logic                hold_hit;

  assign term     = s_ack | s_err | s_rty;
  assign hold_hit = (MAX_HOLD > 0) && (int'(hold_cnt_q) >= MAX_HOLD);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Preemption only fires at a transfer boundary: no strobe, or a termination this cycle.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    if ((state_q == OWN0 || state_q == OWN1) && int'(hold_cnt_q) < MAX_HOLD)
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    unique case (state_q)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_owner_q)) begin
          state_d      = OWN0;
          last_owner_d = 1'b0;
          hold_cnt_d   = '0;
        end else if (m1_cyc) begin
          state_d      = OWN1;
          last_owner_d = 1'b1;
          hold_cnt_d   = '0;
        end
      end
      OWN0: begin
        if (!m0_cyc || (hold_hit && m1_cyc && (!m0_stb || term)))
          state_d = IDLE;
      end
      OWN1: begin
        if (!m1_cyc || (hold_hit && m0_cyc && (!m1_stb || term)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rty   = 1'b0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rty   = 1'b0;
    grant    = 2'b00;
    unique case (state_q)
      OWN0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        m0_ack   = s_ack;
        m0_err   = s_err;
        m0_rty   = s_rty;
        grant    = 2'b01;
      end
      OWN1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        m1_ack   = s_ack;
        m1_err   = s_err;
        m1_rty   = s_rty;
        grant    = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule
